// File: rtl/fetcher_pkg.sv
// Shared state codes for the SIMD control path and the instruction fetcher.
package fetcher_pkg;

  typedef enum logic [2:0] {
    SIMD_IDLE    = 3'd0,
    SIMD_FETCH   = 3'd1,
    SIMD_DECODE  = 3'd2,
    SIMD_REQUEST = 3'd3,
    SIMD_WAIT    = 3'd4,
    SIMD_EXECUTE = 3'd5,
    SIMD_UPDATE  = 3'd6,
    SIMD_DONE    = 3'd7
  } simd_state_t;

  typedef enum logic [1:0] {
    FETCH_IDLE     = 2'b00,
    FETCH_FETCHING = 2'b01,
    FETCH_FETCHED  = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/fetcher.sv
// Per-SIMD instruction fetcher: one request per SIMD_FETCH, latches the word for the decoder.
// Request issues 1 cycle after SIMD_FETCH, instruction valid 1 cycle after ready; memory may stall indefinitely.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_WIDTH = 6,
  parameter int PROGRAM_MEM_DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [2:0]                        simd_state,
  input  logic                              DISPATCH_NEW_WAVE,
  input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc,
  output logic                              mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] mem_read_address,
  input  logic                              mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_WIDTH-1:0] mem_read_data,
  output logic [1:0]                        fetcher_state,
  output logic [PROGRAM_MEM_DATA_WIDTH-1:0] instruction
);

  fetch_state_t                       r_state;
  logic                               r_mem_read_valid;
  logic [PROGRAM_MEM_ADDR_WIDTH-1:0]  r_mem_read_address;
  logic [PROGRAM_MEM_DATA_WIDTH-1:0]  r_instruction;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= FETCH_IDLE;
      r_mem_read_valid   <= 1'b0;
      r_mem_read_address <= '0;
      r_instruction      <= '0;
    end else if (enable) begin
      // A new wave abandons any outstanding request, even one completing this cycle.
      if (DISPATCH_NEW_WAVE) begin
        r_state          <= FETCH_IDLE;
        r_mem_read_valid <= 1'b0;
      end else begin
        case (r_state)
          FETCH_IDLE: begin
            if (simd_state == SIMD_FETCH) begin
              r_state            <= FETCH_FETCHING;
              r_mem_read_valid   <= 1'b1;
              r_mem_read_address <= pc;
            end
          end
          FETCH_FETCHING: begin
            if (mem_read_ready) begin
              r_state          <= FETCH_FETCHED;
              r_mem_read_valid <= 1'b0;
              r_instruction    <= mem_read_data;
            end
          end
          FETCH_FETCHED: begin
            if (simd_state == SIMD_DECODE) begin
              r_state <= FETCH_IDLE;
            end
          end
          default: begin
            r_state          <= FETCH_IDLE;
            r_mem_read_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_read_valid   = r_mem_read_valid;
  assign mem_read_address = r_mem_read_address;
  assign fetcher_state    = r_state;
  assign instruction      = r_instruction;

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher: hand-computed expectations checked after each clock edge.
module tb_fetcher;
  import fetcher_pkg::*;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  simd_state;
  logic        DISPATCH_NEW_WAVE;
  logic [5:0]  pc;
  logic        mem_read_valid;
  logic [5:0]  mem_read_address;
  logic        mem_read_ready;
  logic [31:0] mem_read_data;
  logic [1:0]  fetcher_state;
  logic [31:0] instruction;

  int n_tests;
  int n_fail;

  fetcher #(
    .PROGRAM_MEM_ADDR_WIDTH(6),
    .PROGRAM_MEM_DATA_WIDTH(32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .simd_state        (simd_state),
    .DISPATCH_NEW_WAVE (DISPATCH_NEW_WAVE),
    .pc                (pc),
    .mem_read_valid    (mem_read_valid),
    .mem_read_address  (mem_read_address),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data),
    .fetcher_state     (fetcher_state),
    .instruction       (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic vld,
                         input logic [5:0] addr, input logic [31:0] ins);
    chk({tag, ".state"}, 32'(fetcher_state), 32'(st));
    chk({tag, ".valid"}, 32'(mem_read_valid), 32'(vld));
    chk({tag, ".addr"},  32'(mem_read_address), 32'(addr));
    chk({tag, ".instr"}, instruction, ins);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; enable = 1'b0; simd_state = SIMD_IDLE; DISPATCH_NEW_WAVE = 1'b0;
    pc = 6'd0; mem_read_ready = 1'b0; mem_read_data = 32'h0;
    tick(); tick();
    chk_all("reset", 2'b00, 1'b0, 6'd0, 32'h0);
    rst = 1'b0; enable = 1'b1;

    // Fetch from pc=5, memory stalls 3 cycles, pc moves to 9 meanwhile.
    simd_state = SIMD_FETCH; pc = 6'd5;
    tick();
    chk_all("issue", 2'b01, 1'b1, 6'd5, 32'h0);
    simd_state = SIMD_WAIT;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) pc = 6'd9;
      tick();
      chk_all("stall", 2'b01, 1'b1, 6'd5, 32'h0);
    end
    mem_read_ready = 1'b1; mem_read_data = 32'hDEADBEEF;
    tick();
    chk_all("latch", 2'b10, 1'b0, 6'd5, 32'hDEADBEEF);

    // Ready while FETCHED is ignored.
    mem_read_data = 32'h55;
    tick();
    chk_all("fetched_ready", 2'b10, 1'b0, 6'd5, 32'hDEADBEEF);
    mem_read_ready = 1'b0;

    simd_state = SIMD_DECODE;
    tick();
    chk_all("decode", 2'b00, 1'b0, 6'd5, 32'hDEADBEEF);

    // Ready while IDLE is ignored.
    simd_state = SIMD_WAIT; mem_read_ready = 1'b1; mem_read_data = 32'h77;
    tick();
    chk_all("idle_ready", 2'b00, 1'b0, 6'd5, 32'hDEADBEEF);
    mem_read_ready = 1'b0;

    // New wave coincident with ready aborts the fetch.
    simd_state = SIMD_FETCH; pc = 6'd3;
    tick();
    chk_all("issue2", 2'b01, 1'b1, 6'd3, 32'hDEADBEEF);
    simd_state = SIMD_WAIT; mem_read_ready = 1'b1; mem_read_data = 32'h1234; DISPATCH_NEW_WAVE = 1'b1;
    tick();
    chk_all("dispatch", 2'b00, 1'b0, 6'd3, 32'hDEADBEEF);
    mem_read_ready = 1'b0; DISPATCH_NEW_WAVE = 1'b0;

    // Enable low freezes a pending fetch even with ready high.
    simd_state = SIMD_FETCH; pc = 6'd12;
    tick();
    chk_all("issue3", 2'b01, 1'b1, 6'd12, 32'hDEADBEEF);
    enable = 1'b0; simd_state = SIMD_WAIT; mem_read_ready = 1'b1; mem_read_data = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("hold", 2'b01, 1'b1, 6'd12, 32'hDEADBEEF);
    end
    enable = 1'b1;
    tick();
    chk_all("resume", 2'b10, 1'b0, 6'd12, 32'hCAFEF00D);
    mem_read_ready = 1'b0;

    // Reset mid-fetch (with enable low) wins; later ready ignored.
    simd_state = SIMD_DECODE;
    tick();
    chk_all("decode2", 2'b00, 1'b0, 6'd12, 32'hCAFEF00D);
    simd_state = SIMD_FETCH; pc = 6'd7;
    tick();
    chk_all("issue4", 2'b01, 1'b1, 6'd7, 32'hCAFEF00D);
    rst = 1'b1; enable = 1'b0; simd_state = SIMD_WAIT;
    tick();
    chk_all("rst_mid", 2'b00, 1'b0, 6'd0, 32'h0);
    rst = 1'b0; enable = 1'b1; mem_read_ready = 1'b1; mem_read_data = 32'hABCD;
    tick();
    chk_all("post_rst", 2'b00, 1'b0, 6'd0, 32'h0);
    mem_read_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
